rr_arbiter_4: RTL and testbench
===============================

Name: rr_arbiter_4

Overview:
- 4-requester round-robin arbiter with bounded grant tenure.
- Produces the 2-bit grant index and grant-valid that drive the 2:4 decoder's select (D) and enable (en) inputs. The decoder turns these into one-hot select lines.
- Sits directly upstream of the decoder.
- Registered outputs; one arbitration decision per clock.

Parameters:
- MAX_HOLD, 4: maximum consecutive cycles a requester keeps the grant while others wait. Legal range is 1 and up; 0 is illegal and the block asserts on it at elaboration.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- req  input  4  request vector; bit i is requester i, level-sensitive
- gnt_idx  output  2  index of the granted requester (feeds decoder D)
- gnt_valid  output  1  grant active (feeds decoder en)
- gnt_new  output  1  one-cycle pulse in the first cycle of each newly issued grant

Behaviour:
- Reset: asserting rst_n low clears immediately, without waiting for a clock edge.
  - gnt_valid=0, gnt_idx=2'b00, gnt_new=0.
  - Internal last-grant pointer last=3, so the first search starts at index 0.
  - hold_cnt=0, state=IDLE.
- States: IDLE, GRANT.
- Pick function: first set bit of the candidate vector, searching (last+1), (last+2), (last+3), (last+4) mod 4. Every grant issue sets last to the issued index.
- IDLE:
  - If req!=0: the next edge enters GRANT with gnt_idx=pick(req), gnt_valid=1, gnt_new=1, hold_cnt=1.
  - Otherwise stay in IDLE. Latency from req to grant is 1 cycle.
- GRANT, holder drops (req[gnt_idx]==0):
  - If other requests are pending, issue pick(req) on the next edge back-to-back, with no gnt_valid gap. gnt_new=1, hold_cnt=1.
  - If req==0, go to IDLE: gnt_valid=0, gnt_new=0, gnt_idx holds its last value.
- GRANT, holder still requesting, hold_cnt<MAX_HOLD: keep the grant, hold_cnt+1, gnt_new=0.
- GRANT, holder still requesting, hold_cnt==MAX_HOLD:
  - If any other bit is set, force rotation: issue pick(req with the holder's bit masked), gnt_new=1, hold_cnt=1.
  - If no other request exists, keep the grant and saturate hold_cnt at MAX_HOLD. No gnt_new.
- Widths:
  - hold_cnt is $clog2(MAX_HOLD+1) bits and never wraps.
  - The index rotation is mod-4 wrap; pointer 3 plus 1 gives 0.
- Same-cycle event: holder drop and hold expiry together are treated as a drop.
- Requests that rise and fall while not granted are not remembered; req is level-only.
- gnt_idx changes only on the edge where gnt_new rises or on reset.

Optional Feature:
- Macro: RR_ARBITER_4_PRIO0_EN.
- Defined: requester 0 has preemptive priority. In any cycle where req[0]=1 and the current grant is not 0, the next edge grants index 0 with gnt_new=1 and hold_cnt=1. This overrides round-robin order and tenure, and applies from IDLE too. While requester 0 holds the grant, MAX_HOLD still forces rotation if others wait. Requester 0 may then re-preempt only after a full cycle with req[0]=0.
- Undefined: pure round-robin as above, with no preemption logic synthesized.

Decomposition:
- Package rr_arb_pkg:
  - NUM_REQ=4, IDX_W=2.
  - State enum {IDLE, GRANT}.
  - Function next_ptr(idx) returning (idx+1) mod NUM_REQ.
- Sub-module rr_pick_next:
  - Combinational. Inputs: 4-bit candidate vector and 2-bit pointer. Outputs: 2-bit index and found flag.
  - Instantiated once. The masked and unmasked candidate vectors are muxed in front of it.

Test Plan:
- Reset: hold rst_n=0 with req=4'b1111 -> gnt_valid=0, gnt_idx=00, gnt_new=0. Drop rst_n asynchronously mid-grant -> outputs clear before the next clk edge.
- Single request from IDLE: req=4'b0100 -> one edge later gnt_idx=10, gnt_valid=1, gnt_new high for exactly 1 cycle. Hold for 10 cycles -> gnt_idx stays 10, no further gnt_new.
- Full contention, MAX_HOLD=4, req=4'b1111 from reset -> grants 0,1,2,3,0, each lasting exactly 4 cycles, with gnt_new at each change and no gnt_valid gaps.
- Back-to-back release: grant on 01 with req=4'b1010, then req→4'b1000 -> next edge gnt_idx=11, gnt_valid stays 1, gnt_new=1. Then req→0 -> gnt_valid=0, gnt_idx stays 11.
- Wrap-around: last=3 and req=4'b1001 after release -> grant 0, not 3. Then last=0 with req=4'b1001 -> grant 3.
- With RR_ARBITER_4_PRIO0_EN: grant on 10 at hold_cnt=1, raise req[0] -> next edge gnt_idx=00, gnt_new=1. Without the macro, the same stimulus keeps 10 for 4 cycles.

Source files
------------

// File: rtl/rr_arb_pkg.sv
// Shared types and helpers for the 4-requester round-robin arbiter.
package rr_arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int IDX_W   = 2;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] idx);
    return (idx == IDX_W'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
  endfunction

endpackage

// File: rtl/rr_pick_next.sv
// Combinational round-robin search: first set candidate bit after ptr, wrapping mod NUM_REQ.
module rr_pick_next
  import rr_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] cand,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   idx,
  output logic               found
);

  logic [IDX_W-1:0] probe;

  // ptr itself is probed last, so the previous winner has lowest priority
  always_comb begin
    idx   = '0;
    found = 1'b0;
    probe = ptr;
    for (int k = 0; k < NUM_REQ; k++) begin
      probe = next_ptr(probe);
      if (!found && cand[probe]) begin
        idx   = probe;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_arbiter_4.sv
// Round-robin arbiter with bounded grant tenure, driving a 2:4 decoder's D/en inputs.
// Define RR_ARBITER_4_PRIO0_EN to give requester 0 preemptive priority.
module rr_arbiter_4
  import rr_arb_pkg::*;
#(
  parameter int MAX_HOLD = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req,
  output logic [IDX_W-1:0]     gnt_idx,
  output logic                 gnt_valid,
  output logic                 gnt_new
);

  localparam int              HOLD_W     = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_LIMIT = HOLD_W'(MAX_HOLD);

  generate
    if (MAX_HOLD < 1) begin : g_bad_max_hold
      $error("rr_arbiter_4: MAX_HOLD must be at least 1");
    end
  endgenerate

  state_t             state;
  logic [IDX_W-1:0]   last;
  logic [HOLD_W-1:0]  hold_cnt;

  logic [NUM_REQ-1:0] holder_mask;
  logic [NUM_REQ-1:0] others;
  logic [NUM_REQ-1:0] cand;
  logic               holder_req;
  logic               expire;
  logic               rr_issue;
  logic               issue;
  logic [IDX_W-1:0]   pick_idx;
  logic [IDX_W-1:0]   issue_idx;
  logic               pick_found;

  assign holder_mask = NUM_REQ'(1) << gnt_idx;
  assign others      = req & ~holder_mask;
  assign holder_req  = (state == GRANT) && |(req & holder_mask);

  // A drop in the same cycle as tenure expiry is handled as a plain drop
  assign expire = holder_req && (hold_cnt == HOLD_LIMIT) && (|others);
  assign cand   = expire ? others : req;

  rr_pick_next u_pick (
    .cand  (cand),
    .ptr   (last),
    .idx   (pick_idx),
    .found (pick_found)
  );

  assign rr_issue = pick_found && (!holder_req || expire);

`ifdef RR_ARBITER_4_PRIO0_EN
  logic prio_blk;
  logic preempt;

  // Once requester 0 has been passed over it must release req[0] before preempting again
  assign preempt   = req[0] && !(state == GRANT && gnt_idx == '0) && !prio_blk;
  assign issue     = preempt || rr_issue;
  assign issue_idx = preempt ? '0 : pick_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_blk <= 1'b0;
    end else if (!req[0]) begin
      prio_blk <= 1'b0;
    end else if (issue && issue_idx != '0) begin
      prio_blk <= 1'b1;
    end
  end
`else
  assign issue     = rr_issue;
  assign issue_idx = pick_idx;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      gnt_idx   <= '0;
      gnt_valid <= 1'b0;
      gnt_new   <= 1'b0;
      last      <= IDX_W'(NUM_REQ - 1);
      hold_cnt  <= '0;
    end else if (issue) begin
      state     <= GRANT;
      gnt_idx   <= issue_idx;
      last      <= issue_idx;
      gnt_valid <= 1'b1;
      gnt_new   <= 1'b1;
      hold_cnt  <= HOLD_W'(1);
    end else if (holder_req) begin
      gnt_new <= 1'b0;
      if (hold_cnt != HOLD_LIMIT) begin
        hold_cnt <= hold_cnt + 1'b1;
      end
    end else begin
      // gnt_idx deliberately keeps its last value while idle
      state     <= IDLE;
      gnt_valid <= 1'b0;
      gnt_new   <= 1'b0;
      hold_cnt  <= '0;
    end
  end

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Self-checking bench for rr_arbiter_4: directed table, multi-cycle sequences and random vs. model.
module tb_rr_arbiter_4;

  localparam int MAX_HOLD = 4;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req   = 4'b0000;
  logic [1:0] gnt_idx;
  logic       gnt_valid;
  logic       gnt_new;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [3:0] req;
    logic       exp_valid;
    logic [1:0] exp_idx;
    logic       exp_new;
  } vec_t;

  vec_t vecs[$];

  int m_valid, m_idx, m_new, m_last, m_tenure, m_blk;

  rr_arbiter_4 #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .gnt_new   (gnt_new)
  );

  always #5 clk = ~clk;

  function automatic int rrSearch(input int vec, input int from);
    for (int k = 1; k <= 4; k++) begin
      int c;
      c = (from + k) % 4;
      if (((vec >> c) & 1) != 0) return c;
    end
    return -1;
  endfunction

  task automatic modelReset();
    m_valid = 0; m_idx = 0; m_new = 0; m_last = 3; m_tenure = 0; m_blk = 0;
  endtask

  task automatic modelStep(input int r);
    int others, pick, preempt, holding;
    others  = r & ~(1 << m_idx);
    holding = m_valid && (((r >> m_idx) & 1) != 0);
    preempt = 0;
`ifdef RR_ARBITER_4_PRIO0_EN
    preempt = ((r & 1) != 0) && !(m_valid && m_idx == 0) && (m_blk == 0);
`endif
    pick = -1;
    if (preempt) pick = 0;
    else if (!holding) pick = rrSearch(r, m_last);
    else if (m_tenure >= MAX_HOLD && others != 0) pick = rrSearch(others, m_last);
    if (pick >= 0) begin
      if (((r & 1) != 0) && pick != 0) m_blk = 1;
      m_valid = 1; m_idx = pick; m_last = pick; m_new = 1; m_tenure = 1;
    end else if (holding) begin
      m_new = 0;
      if (m_tenure < MAX_HOLD) m_tenure++;
    end else begin
      m_valid = 0; m_new = 0; m_tenure = 0;
    end
    if ((r & 1) == 0) m_blk = 0;
  endtask

  task automatic applyStimulus(input logic [3:0] r);
    req = r;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic ev, input logic [1:0] ei,
                             input logic en);
    checks++;
    if (gnt_valid !== ev || gnt_idx !== ei || gnt_new !== en) begin
      errors++;
      $display("[TB] FAIL %s: got valid=%0b idx=%0d new=%0b, want valid=%0b idx=%0d new=%0b",
               name, gnt_valid, gnt_idx, gnt_new, ev, ei, en);
    end
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    req   = 4'b0000;
    modelReset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic addVec(input logic [3:0] r, input logic v, input logic [1:0] i, input logic n);
    vec_t e;
    e.req = r; e.exp_valid = v; e.exp_idx = i; e.exp_new = n;
    vecs.push_back(e);
  endtask

  initial begin
    int prev;
    logic [3:0] r;

    addVec(4'b0100, 1'b1, 2'd2, 1'b1);
    for (int i = 0; i < 9; i++) addVec(4'b0100, 1'b1, 2'd2, 1'b0);
    addVec(4'b0010, 1'b1, 2'd1, 1'b1);
    addVec(4'b1010, 1'b1, 2'd1, 1'b0);
    addVec(4'b1000, 1'b1, 2'd3, 1'b1);
    addVec(4'b0000, 1'b0, 2'd3, 1'b0);
    addVec(4'b1001, 1'b1, 2'd0, 1'b1);
    addVec(4'b0000, 1'b0, 2'd0, 1'b0);
`ifdef RR_ARBITER_4_PRIO0_EN
    addVec(4'b1001, 1'b1, 2'd0, 1'b1);
    addVec(4'b0000, 1'b0, 2'd0, 1'b0);
`else
    addVec(4'b1001, 1'b1, 2'd3, 1'b1);
    addVec(4'b0000, 1'b0, 2'd3, 1'b0);
`endif

    // Reset held with every requester active
    rst_n = 1'b0;
    req   = 4'b1111;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_hold", 1'b0, 2'd0, 1'b0);
    req   = 4'b0000;
    rst_n = 1'b1;

    doReset();
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].req);
      checkOutput($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_idx, vecs[i].exp_new);
    end

    // Full contention: each requester holds for exactly MAX_HOLD cycles
    doReset();
    for (int c = 0; c < 5 * MAX_HOLD; c++) begin
      applyStimulus(4'b1111);
      checkOutput($sformatf("contend%0d", c), 1'b1, 2'((c / MAX_HOLD) % 4),
                  (c % MAX_HOLD) == 0);
    end

    // Asynchronous reset in the middle of a grant, checked before the next edge
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset", 1'b0, 2'd0, 1'b0);
    req   = 4'b0000;
    rst_n = 1'b1;

    // Requester 0 arrives one cycle into a grant on requester 2
    doReset();
    applyStimulus(4'b0100);
    checkOutput("prio_start", 1'b1, 2'd2, 1'b0 == 1'b0);
`ifdef RR_ARBITER_4_PRIO0_EN
    applyStimulus(4'b0101);
    checkOutput("prio_preempt", 1'b1, 2'd0, 1'b1);
`else
    for (int c = 0; c < MAX_HOLD - 1; c++) begin
      applyStimulus(4'b0101);
      checkOutput($sformatf("prio_hold%0d", c), 1'b1, 2'd2, 1'b0);
    end
    applyStimulus(4'b0101);
    checkOutput("prio_rotate", 1'b1, 2'd0, 1'b1);
`endif

    // Random traffic against the reference model
    doReset();
    prev = 0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 2) == 0) prev = int'($urandom_range(0, 15));
      r = 4'(prev);
      applyStimulus(r);
      modelStep(prev);
      checkOutput($sformatf("random%0d", c), m_valid != 0, 2'(m_idx), m_new != 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
